// File: rtl/mips_core_pkg.sv
// Shared core types for the branch prediction path: outcome encoding, PHT counter
// type and the PHT port arbiter state encoding.
package mips_core_pkg;

   localparam int ADDR_WIDTH = 32;

   typedef enum logic {
      NOT_TAKEN = 1'b0,
      TAKEN     = 1'b1
   } BranchOutcome;

   typedef logic [1:0] PhtCounter;

   localparam PhtCounter PHT_WEAK_NOT_TAKEN = 2'b01;
   localparam PhtCounter PHT_COUNTER_MAX    = 2'b11;
   localparam PhtCounter PHT_COUNTER_MIN    = 2'b00;

   typedef enum logic [1:0] {
      ARB_IDLE      = 2'd0,
      ARB_UPD_READ  = 2'd1,
      ARB_UPD_WRITE = 2'd2
   } PhtArbState;

   // Saturating step of a 2-bit counter toward the resolved outcome.
   function automatic PhtCounter pht_next_count(input PhtCounter cnt, input BranchOutcome outcome);
      PhtCounter result;
      result = cnt;
      if (outcome == TAKEN) begin
         if (cnt != PHT_COUNTER_MAX) begin
            result = cnt + 2'b01;
         end
      end else begin
         if (cnt != PHT_COUNTER_MIN) begin
            result = cnt - 2'b01;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/pht_fb_fifo.sv
// Small circular FIFO holding resolved-branch feedback (PHT index + outcome) until
// the arbiter finds an idle port cycle to retire it.
module pht_fb_fifo
   import mips_core_pkg::*;
#(
   parameter int INDEX_BITS = 6,
   parameter int FB_DEPTH   = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        push,
   input  logic [INDEX_BITS-1:0]       push_index,
   input  BranchOutcome                push_outcome,
   input  logic                        pop,
   output logic [INDEX_BITS-1:0]       head_index,
   output BranchOutcome                head_outcome,
   output logic                        full,
   output logic                        empty,
   output logic [$clog2(FB_DEPTH):0]   count
);

   localparam int PTR_BITS   = $clog2(FB_DEPTH);
   localparam int COUNT_BITS = PTR_BITS + 1;

   logic [INDEX_BITS-1:0] index_mem   [FB_DEPTH];
   BranchOutcome          outcome_mem [FB_DEPTH];
   logic [PTR_BITS-1:0]   wr_ptr;
   logic [PTR_BITS-1:0]   rd_ptr;

   assign head_index   = index_mem[rd_ptr];
   assign head_outcome = outcome_mem[rd_ptr];
   assign full         = (count == COUNT_BITS'(FB_DEPTH));
   assign empty        = (count == '0);

   // Payload storage needs no reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         index_mem[wr_ptr]   <= push_index;
         outcome_mem[wr_ptr] <= push_outcome;
      end
   end

   // Depth is a power of two, so pointer overflow is the modulo wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_BITS'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_BITS'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + COUNT_BITS'(1);
            2'b01:   count <= count - COUNT_BITS'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/pht_port_arbiter.sv
// Single-port PHT of 2-bit counters shared between decode lookups and queued EX feedback.
// Define PHT_ARB_FWD_EN to forward an in-flight update value to a lookup of the same index.
module pht_port_arbiter
   import mips_core_pkg::*;
#(
   parameter int INDEX_BITS = 6,
   parameter int FB_DEPTH   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_req_valid,
   input  logic [ADDR_WIDTH-1:0] i_req_pc,
   output logic                  o_req_ready,
   output logic                  o_rsp_valid,
   output BranchOutcome          o_rsp_prediction,
   input  logic                  i_fb_valid,
   input  logic [ADDR_WIDTH-1:0] i_fb_pc,
   input  BranchOutcome          i_fb_outcome,
   output logic                  o_fb_overflow
);

   localparam int PHT_ENTRIES = 2 ** INDEX_BITS;
   localparam int COUNT_W     = $clog2(FB_DEPTH) + 1;

   PhtCounter             pht_table [PHT_ENTRIES];
   PhtArbState            state;
   PhtArbState            state_next;

   logic [INDEX_BITS-1:0] req_index;
   logic [INDEX_BITS-1:0] fb_index;
   logic [INDEX_BITS-1:0] upd_index;
   BranchOutcome          upd_outcome;
   PhtCounter             rd_cnt;
   PhtCounter             wr_cnt;
   PhtCounter             lookup_value;

   logic                  lookup_fire;
   logic                  port_granted;
   logic                  upd_read_fire;
   logic                  upd_write_fire;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  fifo_refill;
   logic [COUNT_W-1:0]    fifo_count;
   logic [INDEX_BITS-1:0] head_index;
   BranchOutcome          head_outcome;
   logic                  unused_pc_bits;

   assign req_index      = i_req_pc[INDEX_BITS+1:2];
   assign fb_index       = i_fb_pc[INDEX_BITS+1:2];
   assign unused_pc_bits = ^{i_req_pc[ADDR_WIDTH-1:INDEX_BITS+2], i_req_pc[1:0],
                             i_fb_pc[ADDR_WIDTH-1:INDEX_BITS+2], i_fb_pc[1:0]};

   // A full feedback queue takes the port away from decode until one entry retires.
   assign o_req_ready    = ~fifo_full;
   assign lookup_fire    = i_req_valid & o_req_ready;
   assign port_granted   = ~lookup_fire;
   assign upd_read_fire  = (state == ARB_UPD_READ) & port_granted;
   assign upd_write_fire = (state == ARB_UPD_WRITE) & port_granted;

   // A push into a full queue is still legal when the head retires in the same cycle.
   assign fifo_pop       = upd_write_fire;
   assign fifo_push      = i_fb_valid & (~fifo_full | fifo_pop);
   assign fifo_refill    = (fifo_count > COUNT_W'(1)) | fifo_push;

   assign wr_cnt         = pht_next_count(rd_cnt, upd_outcome);

`ifdef PHT_ARB_FWD_EN
   assign lookup_value = ((state == ARB_UPD_WRITE) && (upd_index == req_index))
                         ? wr_cnt : pht_table[req_index];
`else
   assign lookup_value = pht_table[req_index];
`endif

   pht_fb_fifo #(
      .INDEX_BITS (INDEX_BITS),
      .FB_DEPTH   (FB_DEPTH)
   ) u_fb_fifo (
      .clk          (clk),
      .rst          (rst),
      .push         (fifo_push),
      .push_index   (fb_index),
      .push_outcome (i_fb_outcome),
      .pop          (fifo_pop),
      .head_index   (head_index),
      .head_outcome (head_outcome),
      .full         (fifo_full),
      .empty        (fifo_empty),
      .count        (fifo_count)
   );

   always_comb begin
      state_next = state;
      unique case (state)
         ARB_IDLE: begin
            if (!fifo_empty) begin
               state_next = ARB_UPD_READ;
            end
         end
         ARB_UPD_READ: begin
            if (port_granted) begin
               state_next = ARB_UPD_WRITE;
            end
         end
         ARB_UPD_WRITE: begin
            if (port_granted) begin
               state_next = fifo_refill ? ARB_UPD_READ : ARB_IDLE;
            end
         end
         default: state_next = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ARB_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // The head entry is captured with its old counter so the write cycle is self-contained.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_cnt      <= PHT_WEAK_NOT_TAKEN;
         upd_index   <= '0;
         upd_outcome <= NOT_TAKEN;
      end else if (upd_read_fire) begin
         rd_cnt      <= pht_table[head_index];
         upd_index   <= head_index;
         upd_outcome <= head_outcome;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < PHT_ENTRIES; i++) begin
            pht_table[i] <= PHT_WEAK_NOT_TAKEN;
         end
      end else if (upd_write_fire) begin
         pht_table[upd_index] <= wr_cnt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_rsp_valid      <= 1'b0;
         o_rsp_prediction <= NOT_TAKEN;
      end else begin
         o_rsp_valid <= lookup_fire;
         if (lookup_fire) begin
            o_rsp_prediction <= lookup_value[1] ? TAKEN : NOT_TAKEN;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_fb_overflow <= 1'b0;
      end else if (i_fb_valid && fifo_full && !fifo_pop) begin
         o_fb_overflow <= 1'b1;
      end
   end

endmodule
